// File: rtl/mips_pkg.sv
// Shared constants and payload types for the mips front end.
package mips_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto an instruction-word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Register-based synchronous FIFO of fetch entries with a synchronous flush.
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_ok;
    logic           rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head never shows stale garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch stage: credit-limited word reads, in-order response
// buffering and redirect handling with stale-response discard.
module ifetch_prefetch
    import mips_pkg::*;
#(
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;

    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] rsp_pc_nxt;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   drop_cnt_nxt;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    logic [XLEN-1:0] redirect_pc_aligned;
    logic [SW-1:0]   occupancy;
    logic            credit;
    logic            req;
    logic            accept;
    logic            rsp_ok;
    logic            rsp_drop;
    logic            push;
    logic            pop;

    assign redirect_pc_aligned = word_align(redirect_pc);

    // Buffered plus in-flight words may never exceed the FIFO capacity.
    assign occupancy = SW'(fifo_count) + SW'(outstanding);
    assign credit    = !fifo_full && (occupancy < SW'(DEPTH));
    assign req       = !reset && !redirect && credit;
    assign accept    = req && imem_gnt;

    // A response with nothing outstanding is a bus protocol error and is ignored.
    assign rsp_ok   = imem_rvalid && (outstanding != '0);
    assign rsp_drop = rsp_ok && (drop_cnt != '0);
    assign push     = rsp_ok && (drop_cnt == '0) && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;

    assign push_entry = '{pc: rsp_pc, instr: imem_rdata};

    // Next-state for fetch/response addresses and the in-flight bookkeeping.
    always_comb begin
        fetch_pc_nxt    = fetch_pc;
        rsp_pc_nxt      = rsp_pc;
        outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_ok);
        drop_cnt_nxt    = drop_cnt;

        if (redirect) begin
            // Everything still in flight belongs to the abandoned path.
            fetch_pc_nxt    = redirect_pc_aligned;
            rsp_pc_nxt      = redirect_pc_aligned;
            outstanding_nxt = outstanding - CW'(rsp_ok);
            drop_cnt_nxt    = outstanding - CW'(rsp_ok);
        end else begin
            if (accept) begin
                fetch_pc_nxt = fetch_pc + XLEN'(INSTR_BYTES);
            end
            if (push) begin
                rsp_pc_nxt = rsp_pc + XLEN'(INSTR_BYTES);
            end
            if (rsp_drop) begin
                drop_cnt_nxt = drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            rsp_pc      <= rsp_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign imem_req    = req;
    assign imem_addr   = fetch_pc;
    assign instr_valid = !reset && !fifo_empty;
    assign instr       = instr_valid ? fifo_head.instr : '0;
    assign instr_pc    = instr_valid ? fifo_head.pc    : '0;

    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (outstanding == '0)));

    a_credit_bound : assert property (@(posedge clk) disable iff (reset)
        occupancy <= SW'(DEPTH));

    a_drop_bound : assert property (@(posedge clk) disable iff (reset)
        drop_cnt <= outstanding);

endmodule
